// File: rtl/irq_requester.sv
// irq_requester: synchronised, edge-detected interrupt lines arbitrated by
// fixed priority into an active-low request with REQ/SVC handshake tracking.
module irq_requester #(
  parameter int NUM_IRQ     = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               ISR_en,
  input  logic               sel_ISR,
  input  logic               ret_ISR,
  output logic               interrupt_signal,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               irq_active
);

  localparam int WU_MAX = SYNC_STAGES + 1;
  localparam int WU_W   = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SVC
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_d;
  logic [WU_W-1:0]    wu_cnt;
  logic               wu_done;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] req_vec;
  logic [ID_W-1:0]    id_nxt;
  logic [ID_W-1:0]    win_id;
  logic               win_any;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      sync_d <= '0;
      wu_cnt <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      sync_d <= sync_q[SYNC_STAGES-1];
      if (!wu_done) begin
        wu_cnt <= wu_cnt + 1'b1;
      end
    end
  end

  // Edges are ignored until the chain has refilled after reset, so a
  // line that was already high never looks like a fresh rise.
  assign wu_done = (wu_cnt == WU_W'(WU_MAX));
  assign rise    = sync_q[SYNC_STAGES-1] & ~sync_d
                 & {NUM_IRQ{wu_done}};

  assign req_vec = irq_pending & irq_mask;

  always_comb begin
    win_any = |req_vec;
    win_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      state  <= state_nxt;
      irq_id <= id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    clr       = '0;
    unique case (state)
      IDLE: begin
        if (win_any && ISR_en) begin
          state_nxt = REQ;
          id_nxt    = win_id;
        end
      end
      REQ: begin
        if (sel_ISR) begin
          state_nxt = SVC;
          clr       = NUM_IRQ'(1) << irq_id;
        end
      end
      SVC: begin
        if (ret_ISR) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A set in the same cycle as the clear wins, keeping the new edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      irq_pending <= '0;
    end else begin
      irq_pending <= (irq_pending & ~clr) | rise;
    end
  end

  assign interrupt_signal = (state != REQ);
  assign irq_active       = (state != IDLE);

endmodule
